apb_req_ctrl: RTL
=================

Name: apb_req_ctrl

Overview:
- Parametrised RTL APB requester, a synthesizable successor to the bench-side APB drive interface used in the timer bench.
- Converts a valid/ready command stream into APB3/APB4 transfers: setup and access phases, wait states via pready, pslverr capture, and a wait-state timeout abort.
- Returns one response per command on a valid/ready response channel.
- Sits between a register-sequencer or CPU-side bridge and APB slaves such as the timer.

Parameters:
- ADDR_W, 12, APB byte-address width; paddr carries bits [ADDR_W-1:2].
- DATA_W, 32, data width; must be 8, 16 or 32.
- APB4, 1, 1 drives pstrb/pprot from the command; 0 ties pstrb to all-ones and pprot to 0.
- TIMEOUT, 16, maximum access-phase cycles without pready before abort; 0 disables the timeout.

Ports:
- pclkg  in  1  APB clock; all state on posedge.
- preset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W-2  word address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  DATA_W/8  byte strobes (APB4 only).
- cmd_prot  in  3  protection attributes (APB4 only).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
- rsp_err  out  1  pslverr or timeout.
- rsp_timeout  out  1  abort was caused by timeout.
- psel, penable, pwrite  out  1 each  APB control.
- paddr  out  ADDR_W-2  APB address.
- pwdata  out  DATA_W  APB write data.
- pstrb  out  DATA_W/8  APB4 strobes.
- pprot  out  3  APB4 protection.
- prdata  in  DATA_W  APB read data.
- pready, pslverr  in  1 each  APB completion and error.

Behaviour:
- Reset (async assert, sync release): state=IDLE.
  - psel=penable=pwrite=0; paddr, pwdata, pstrb, pprot = 0.
  - cmd_ready=0 during reset; cmd_ready=1 in IDLE afterwards.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0.
  - Wait counter cleared.
- Four-state FSM: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On handshake, register write/addr/wdata/strb/prot into the APB output flops and go to SETUP.
  - Read commands drive pwdata=0 and pstrb=0, per APB4.
- SETUP (exactly 1 cycle): psel=1, penable=0; go to ACCESS.
- ACCESS: psel=1, penable=1.
  - If pready=1: capture prdata (reads only), pslverr→rsp_err, rsp_timeout=0. Deassert psel/penable the next cycle and go to RESP.
  - If pready=0: increment the wait counter. When TIMEOUT≠0 and the counter reaches TIMEOUT, abort: psel=penable=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
  - A pready arriving in the same cycle the counter hits TIMEOUT wins; the transfer completes normally.
- Latency: zero-wait transfer gives handshake at cycle 0, setup at 1, access at 2, rsp_valid at 3.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready.
  - On rsp_ready: rsp_valid=0, go to IDLE, clear counter.
  - cmd_ready stays 0 throughout RESP. One outstanding transaction only.
- APB stability: paddr, pwrite, pwdata, pstrb, pprot are constant from SETUP through the end of ACCESS. They are not required to clear afterwards.
- Counter width is $clog2(TIMEOUT+1); with TIMEOUT=0 the counter is removed and ACCESS waits indefinitely.
- pslverr and prdata are sampled only when psel & penable & pready.
- Reset asserted mid-transfer forces IDLE with all outputs at reset values immediately. No response is produced for the interrupted command.

Decomposition:
- Package apb_req_pkg holds:
  - state enum (IDLE, SETUP, ACCESS, RESP);
  - PROT_W=3;
  - a response struct {rdata, err, timeout}.
- Sub-module apb_wait_timer holds the wait counter: inputs clear, enable; output expired; parameter TIMEOUT.
- Everything else stays in one module.

Test Plan:
- Zero-wait write: cmd write addr=0x004 (word 0x001), wdata=0xDEADBEEF, strb=0xF, pready=1 → psel high cycles 1–2, penable cycle 2, rsp_valid cycle 3 with err=0, rdata=0.
- Read with 3 wait states: prdata=0x12345678 returned with pready on the 4th access cycle → rsp_rdata=0x12345678, err=0; paddr stable across all ACCESS cycles.
- Slave error: read, pready=1 with pslverr=1 → rsp_err=1, rsp_timeout=0; next command is accepted only after rsp_ready.
- Timeout: TIMEOUT=4, pready held 0 → abort after 4 access cycles with psel=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0. A second run with pready=1 in the limit cycle completes normally.
- Response backpressure then reset: rsp_ready=0 for 5 cycles → outputs held and cmd_ready=0. Assert preset mid-ACCESS of the next command → all outputs 0 the same cycle, IDLE after release.
- APB4=0 build, DATA_W=16: write with cmd_strb=0x1 → pstrb=0x3, pprot=0.

Source files
------------

// File: rtl/apb_req_pkg.sv
// Shared types for the APB requester: FSM states, protection width and the
// response record handed back on the response channel.
package apb_req_pkg;

    localparam int PROT_W     = 3;
    localparam int MAX_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // rdata is sized for the widest legal bus; narrower builds use the low bits
    typedef struct packed {
        logic [MAX_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Access-phase wait-state counter; expired flags the last permitted wait cycle
// so the requester can abort on the same edge.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic pclkg,
    input  logic preset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT + 1);
            // expired is raised while counting the TIMEOUT-th wait cycle
            localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

            logic [CW-1:0] cnt;

            always_ff @(posedge pclkg or posedge preset) begin
                if (preset)      cnt <= '0;
                else if (clear)  cnt <= '0;
                else if (enable) cnt <= cnt + 1'b1;
            end

            assign expired = enable && (cnt == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/apb_req_ctrl.sv
// APB3/APB4 requester: turns a valid/ready command stream into single APB
// transfers and returns one response per command, with wait-state timeout.
module apb_req_ctrl
    import apb_req_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int APB4    = 1,
    parameter int TIMEOUT = 16
) (
    input  logic                pclkg,
    input  logic                preset,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-3:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    input  logic [PROT_W-1:0]   cmd_prot,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,

    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [ADDR_W-3:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    output logic [PROT_W-1:0]   pprot,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pready,
    input  logic                pslverr
);

    localparam int STRB_W = DATA_W / 8;

    state_t state;
    rsp_t   rsp_q;
    logic   expired;

    apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .pclkg   (pclkg),
        .preset  (preset),
        .clear   (state != ACCESS),
        .enable  ((state == ACCESS) && !pready),
        .expired (expired)
    );

    assign rsp_rdata   = rsp_q.rdata[DATA_W-1:0];
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

    always_ff @(posedge pclkg or posedge preset) begin
        if (preset) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            pstrb     <= '0;
            pprot     <= '0;
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        psel      <= 1'b1;
                        penable   <= 1'b0;
                        pwrite    <= cmd_write;
                        paddr     <= cmd_addr;
                        pwdata    <= cmd_write ? cmd_wdata : '0;
                        // APB3 slaves have no strobes: advertise every lane
                        if (APB4 == 0)      pstrb <= {STRB_W{1'b1}};
                        else if (cmd_write) pstrb <= cmd_strb;
                        else                pstrb <= '0;
                        pprot     <= (APB4 != 0) ? cmd_prot : '0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // a late pready beats the timeout in the limit cycle
                    if (pready) begin
                        psel          <= 1'b0;
                        penable       <= 1'b0;
                        rsp_q.rdata   <= pwrite ? '0 : MAX_DATA_W'(prdata);
                        rsp_q.err     <= pslverr;
                        rsp_q.timeout <= 1'b0;
                        rsp_valid     <= 1'b1;
                        state         <= RESP;
                    end else if (expired) begin
                        psel          <= 1'b0;
                        penable       <= 1'b0;
                        rsp_q.rdata   <= '0;
                        rsp_q.err     <= 1'b1;
                        rsp_q.timeout <= 1'b1;
                        rsp_valid     <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
